// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared types and constants for the 74HC595 parallel-to-serial writer.
//   piso_state_e : frame sequencing states of the writer FSM
//   NBIT_DEF     : default word width / shift clocks per frame
//   HALF_PER_DEF : default system clocks per half period of SH_CP/ST_CP
//   frameLen()   : system clocks Ready_O stays low for one frame
// ---------------------------------------------------------------------------
package piso_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SH_LO,
      SH_HI,
      LAT_HI,
      LAT_LO
   } piso_state_e;

   localparam int NBIT_DEF     = 8;
   localparam int HALF_PER_DEF = 2;

   // NBIT shift-clock periods plus one latch-clock period.
   function automatic int frameLen(input int nbit, input int halfPer);
      return 2 * halfPer * (nbit + 1);
   endfunction

endpackage

// File: rtl/piso_phase_timer.sv
// ---------------------------------------------------------------------------
// piso_phase_timer
// Down-counter that measures one half period of the generated clocks.
// Reloaded with HALF_PER-1 on every phase entry; PhaseEnd_O is high during
// the last system clock of the phase so the FSM advances on that edge.
//   Clk_I      : system clock
//   Rst_N_I    : asynchronous active-low reset
//   Load_I     : phase entry, reload the counter
//   PhaseEnd_O : last cycle of the current phase
// ---------------------------------------------------------------------------
module piso_phase_timer #(
   parameter int HALF_PER = 2
) (
   input  logic Clk_I,
   input  logic Rst_N_I,
   input  logic Load_I,
   output logic PhaseEnd_O
);

   localparam int CW = $clog2(HALF_PER + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(HALF_PER - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Reload wins over counting; the counter parks at zero rather than wrapping.
   always_comb begin
      count_d = count_q;
      if (Load_I) begin
         count_d = LOAD_VAL;
      end else if (count_q != '0) begin
         count_d = count_q - CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge Clk_I or negedge Rst_N_I) begin
      if (!Rst_N_I) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign PhaseEnd_O = (count_q == '0);

endmodule

// File: rtl/write_piso_595.sv
// ---------------------------------------------------------------------------
// write_piso_595
// Writes a parallel word into an external 74HC595 chain: shifts the word out
// on Ser_O with a generated SH_CP_O, then pulses ST_CP_O and reports Done_O.
//   Clk_I    : system clock
//   Rst_N_I  : asynchronous active-low reset
//   Parl_I   : word to write, sampled on accept
//   Valid_I  : request; accepted when Ready_O is high
//   Ready_O  : idle, able to accept
//   Ser_O    : serial data to 595 DS
//   SH_CP_O  : shift clock, 595 samples on rising edge
//   ST_CP_O  : latch clock, rising edge transfers to 595 outputs
//   OE_N_O   : 595 output enable, released after the first complete frame
//   Done_O   : one-cycle pulse on return to IDLE
// ---------------------------------------------------------------------------
module write_piso_595
   import piso_pkg::*;
#(
   parameter int NBIT      = NBIT_DEF,
   parameter int HALF_PER  = HALF_PER_DEF,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic            Clk_I,
   input  logic            Rst_N_I,
   input  logic [NBIT-1:0] Parl_I,
   input  logic            Valid_I,
   output logic            Ready_O,
   output logic            Ser_O,
   output logic            SH_CP_O,
   output logic            ST_CP_O,
   output logic            OE_N_O,
   output logic            Done_O
);

   localparam int BCW = $clog2(NBIT + 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(NBIT - 1);

   piso_state_e     state_q;
   logic [NBIT-1:0] shift_q;
   logic [NBIT-1:0] shift_d;
   logic [BCW-1:0]  bitCnt_q;
   logic            accept;
   logic            phaseEnd;
   logic            timerLoad;
   logic            firstBit;
   logic            nextBit;

   // Shift direction chosen at elaboration; the bit on Ser_O is always the
   // outgoing end of the shift register.
   always_comb begin
      shift_d  = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
      firstBit = LSB_FIRST ? Parl_I[0] : Parl_I[NBIT-1];
      nextBit  = LSB_FIRST ? shift_d[0] : shift_d[NBIT-1];
   end

   assign accept = Valid_I & Ready_O;

   // Every state change starts a new half period, so the timer is reloaded
   // exactly when the FSM moves.
   assign timerLoad = (state_q == IDLE) ? accept : phaseEnd;

   piso_phase_timer #(
      .HALF_PER (HALF_PER)
   ) uPhaseTimer (
      .Clk_I      (Clk_I),
      .Rst_N_I    (Rst_N_I),
      .Load_I     (timerLoad),
      .PhaseEnd_O (phaseEnd)
   );

   // Frame FSM with registered outputs. Ser_O only moves on the falling
   // SH_CP_O edge (or in IDLE), keeping setup and hold around each rise.
   always_ff @(posedge Clk_I or negedge Rst_N_I) begin
      if (!Rst_N_I) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bitCnt_q <= '0;
         Ready_O  <= 1'b1;
         Ser_O    <= 1'b0;
         SH_CP_O  <= 1'b0;
         ST_CP_O  <= 1'b0;
         OE_N_O   <= 1'b1;
         Done_O   <= 1'b0;
      end else begin
         Done_O <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  shift_q  <= Parl_I;
                  bitCnt_q <= BIT_LAST;
                  Ser_O    <= firstBit;
                  Ready_O  <= 1'b0;
                  state_q  <= SH_LO;
               end
            end
            SH_LO: begin
               if (phaseEnd) begin
                  SH_CP_O <= 1'b1;
                  state_q <= SH_HI;
               end
            end
            SH_HI: begin
               if (phaseEnd) begin
                  SH_CP_O <= 1'b0;
                  if (bitCnt_q == '0) begin
                     ST_CP_O <= 1'b1;
                     state_q <= LAT_HI;
                  end else begin
                     shift_q  <= shift_d;
                     Ser_O    <= nextBit;
                     bitCnt_q <= bitCnt_q - BCW'(1);
                     state_q  <= SH_LO;
                  end
               end
            end
            LAT_HI: begin
               if (phaseEnd) begin
                  ST_CP_O <= 1'b0;
                  state_q <= LAT_LO;
               end
            end
            LAT_LO: begin
               if (phaseEnd) begin
                  Ready_O <= 1'b1;
                  Done_O  <= 1'b1;
                  OE_N_O  <= 1'b0;
                  Ser_O   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
